ion_request_arbiter: RTL and testbench

ION_REQUEST_ARBITER -- requirements
Module: ion_request_arbiter

---
 rtl/ion_request_arbiter_if.sv | 25 ++
 rtl/ion_request_arbiter.sv | 149 ++++++++++++++
 tb/tb_ion_request_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ion_request_arbiter_if.sv
// Signal bundle between the per-stream requesters, the ion request arbiter and the sensor link.
// The arbiter takes the master view; the environment around it takes the slave view.
interface ion_request_arbiter_if;
    logic [7:0] stream_active;
    logic [7:0] i_s_request;
    logic       cmd_ready;
    logic       resp_done;
    logic       clear_overrun;
    logic       cmd_valid;
    logic [2:0] cmd_stream;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic       timeout_flag;
    logic       busy;

    modport master (
        input  stream_active, i_s_request, cmd_ready, resp_done, clear_overrun,
        output cmd_valid, cmd_stream, pending, overrun, timeout_flag, busy
    );

    modport slave (
        output stream_active, i_s_request, cmd_ready, resp_done, clear_overrun,
        input  cmd_valid, cmd_stream, pending, overrun, timeout_flag, busy
    );
endinterface

// File: rtl/ion_request_arbiter.sv
// Round-robin arbiter issuing one sensor command at a time for eight periodic ion streams,
// with per-stream pending/overrun tracking and a response-wait timeout.
module ion_request_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                   clock,
    input  logic                   reset,
    ion_request_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  cmd_stream_r;
    logic [2:0]  cmd_stream_s;
    logic [2:0]  last_grant_r;
    logic [2:0]  last_grant_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic        timeout_r;
    logic        timeout_s;
    logic        cmd_valid_r;
    logic        busy_r;
    logic        hs_s;
    logic [7:0]  pending_r;
    logic [7:0]  pending_s;
    logic [7:0]  overrun_r;
    logic [7:0]  overrun_s;
    logic [7:0]  req_s;
    logic [7:0]  clr_s;
    logic [7:0]  ov_set_s;

    // First set bit at or above (last + 1), wrapping through stream 7 back to stream 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = last + 3'd1 + 3'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Command FSM: next state, grant selection, response-wait counter and timeout decision.
    always_comb begin
        state_s      = state_r;
        cmd_stream_s = cmd_stream_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        timeout_s    = 1'b0;
        hs_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (pending_r != 8'h00) begin
                    cmd_stream_s = rr_pick(pending_r, last_grant_r);
                    state_s      = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // A stream disabled under an offered command withdraws it; no handshake happens.
                if (!bus.stream_active[cmd_stream_r]) begin
                    state_s = IDLE;
                end else if (bus.cmd_ready) begin
                    hs_s    = 1'b1;
                    cnt_s   = 16'd0;
                    state_s = WAIT_RESP;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT_RESP: begin
                if (bus.resp_done) begin
                    last_grant_s = cmd_stream_r;
                    state_s      = IDLE;
                end else if (cnt_r == (TIMEOUT_CYCLES - 16'd1)) begin
                    last_grant_s = cmd_stream_r;
                    timeout_s    = 1'b1;
                    state_s      = IDLE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Per-stream pending and sticky overrun bookkeeping.
    always_comb begin
        req_s     = bus.i_s_request & bus.stream_active;
        clr_s     = hs_s ? (8'h01 << cmd_stream_r) : 8'h00;
        pending_s = req_s | (pending_r & ~clr_s & bus.stream_active);
        ov_set_s  = req_s & pending_r & ~clr_s;
        if (bus.clear_overrun) begin
            overrun_s = ov_set_s;
        end else begin
            overrun_s = ov_set_s | overrun_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cmd_stream_r <= 3'd0;
            last_grant_r <= 3'd7;
            cnt_r        <= 16'd0;
            timeout_r    <= 1'b0;
            cmd_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            pending_r    <= 8'h00;
            overrun_r    <= 8'h00;
        end else begin
            state_r      <= state_s;
            cmd_stream_r <= cmd_stream_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
            timeout_r    <= timeout_s;
            cmd_valid_r  <= (state_s == ISSUE);
            busy_r       <= (state_s != IDLE);
            pending_r    <= pending_s;
            overrun_r    <= overrun_s;
        end
    end

    assign bus.cmd_valid    = cmd_valid_r;
    assign bus.cmd_stream   = cmd_stream_r;
    assign bus.pending      = pending_r;
    assign bus.overrun      = overrun_r;
    assign bus.timeout_flag = timeout_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_ion_request_arbiter.sv
// Directed bench for ion_request_arbiter with TIMEOUT_CYCLES=10; inputs change 1 ns after
// each rising edge and outputs are sampled at the same point.
module tb_ion_request_arbiter;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ion_request_arbiter_if bus ();

    ion_request_arbiter #(.TIMEOUT_CYCLES(16'd10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rr_exp [4];
        rr_exp[0] = 3'd6;
        rr_exp[1] = 3'd7;
        rr_exp[2] = 3'd0;
        rr_exp[3] = 3'd1;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.stream_active = 8'hFF;
        bus.i_s_request   = 8'h00;
        bus.cmd_ready     = 1'b0;
        bus.resp_done     = 1'b0;
        bus.clear_overrun = 1'b0;

        // Reset state
        step(2);
        check("rst_cmd_valid", 16'(bus.cmd_valid), 16'd0);
        check("rst_cmd_stream", 16'(bus.cmd_stream), 16'd0);
        check("rst_pending", 16'(bus.pending), 16'h00);
        check("rst_overrun", 16'(bus.overrun), 16'h00);
        check("rst_timeout", 16'(bus.timeout_flag), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        reset = 1'b0;
        step(1);

        // Two simultaneous requests: stream 0 then stream 7
        bus.i_s_request = 8'h81;
        step(1);
        bus.i_s_request = 8'h00;
        check("t1_pending", 16'(bus.pending), 16'h81);
        check("t1_idle_valid", 16'(bus.cmd_valid), 16'd0);
        bus.cmd_ready = 1'b1;
        step(1);
        check("t1_valid0", 16'(bus.cmd_valid), 16'd1);
        check("t1_stream0", 16'(bus.cmd_stream), 16'd0);
        check("t1_busy", 16'(bus.busy), 16'd1);
        step(1);
        check("t1_pending_after_hs0", 16'(bus.pending), 16'h80);
        check("t1_valid_wait", 16'(bus.cmd_valid), 16'd0);
        check("t1_busy_wait", 16'(bus.busy), 16'd1);
        step(2);
        bus.resp_done = 1'b1;
        step(1);
        bus.resp_done = 1'b0;
        check("t1_idle_busy", 16'(bus.busy), 16'd0);
        step(1);
        check("t1_valid7", 16'(bus.cmd_valid), 16'd1);
        check("t1_stream7", 16'(bus.cmd_stream), 16'd7);
        step(1);
        check("t1_pending_done", 16'(bus.pending), 16'h00);
        step(2);
        bus.resp_done = 1'b1;
        step(1);
        bus.resp_done = 1'b0;
        bus.cmd_ready = 1'b0;
        check("t1_busy_end", 16'(bus.busy), 16'd0);
        check("t1_overrun", 16'(bus.overrun), 16'h00);

        // Establish last grant = 5
        bus.i_s_request = 8'h20;
        step(1);
        bus.i_s_request = 8'h00;
        bus.cmd_ready = 1'b1;
        step(1);
        check("rr_stream5", 16'(bus.cmd_stream), 16'd5);
        step(1);
        bus.resp_done = 1'b1;
        step(1);
        bus.resp_done = 1'b0;

        // Round robin with all streams held pending
        bus.i_s_request = 8'hFF;
        step(1);
        check("rr_pending_ff", 16'(bus.pending), 16'hFF);
        step(1);
        check("rr_grant0", 16'(bus.cmd_stream), 16'(rr_exp[0]));
        check("rr_valid0", 16'(bus.cmd_valid), 16'd1);
        for (int g = 1; g < 4; g++) begin
            step(1);
            bus.resp_done = 1'b1;
            step(1);
            bus.resp_done = 1'b0;
            step(1);
            check("rr_grant", 16'(bus.cmd_stream), 16'(rr_exp[g]));
            check("rr_pending_held", 16'(bus.pending), 16'hFF);
        end
        check("rr_overrun_all", 16'(bus.overrun), 16'hFF);
        bus.i_s_request = 8'h00;
        bus.stream_active = 8'h00;
        step(1);
        check("rr_abort_pending", 16'(bus.pending), 16'h00);
        check("rr_abort_valid", 16'(bus.cmd_valid), 16'd0);
        check("rr_abort_busy", 16'(bus.busy), 16'd0);
        bus.stream_active = 8'hFF;
        bus.clear_overrun = 1'b1;
        step(1);
        bus.clear_overrun = 1'b0;
        check("rr_overrun_cleared", 16'(bus.overrun), 16'h00);

        // Overrun on stream 2 while stalled in ISSUE
        bus.cmd_ready = 1'b0;
        bus.i_s_request = 8'h04;
        step(1);
        bus.i_s_request = 8'h00;
        step(1);
        check("ov_stream2", 16'(bus.cmd_stream), 16'd2);
        bus.i_s_request = 8'h04;
        step(1);
        bus.i_s_request = 8'h00;
        check("ov_set", 16'(bus.overrun), 16'h04);
        check("ov_pending", 16'(bus.pending), 16'h04);
        bus.clear_overrun = 1'b1;
        step(1);
        check("ov_clear", 16'(bus.overrun), 16'h00);
        bus.i_s_request = 8'h04;
        step(1);
        bus.i_s_request = 8'h00;
        bus.clear_overrun = 1'b0;
        check("ov_clear_vs_set", 16'(bus.overrun), 16'h04);
        bus.clear_overrun = 1'b1;
        step(1);
        bus.clear_overrun = 1'b0;
        check("ov_clear2", 16'(bus.overrun), 16'h00);

        // Timeout: handshake stream 2, no response
        bus.cmd_ready = 1'b1;
        step(1);
        bus.cmd_ready = 1'b0;
        check("to_pending", 16'(bus.pending), 16'h00);
        step(9);
        check("to_not_yet", 16'(bus.timeout_flag), 16'd0);
        check("to_busy_wait", 16'(bus.busy), 16'd1);
        step(1);
        check("to_pulse", 16'(bus.timeout_flag), 16'd1);
        check("to_idle", 16'(bus.busy), 16'd0);
        step(1);
        check("to_pulse_end", 16'(bus.timeout_flag), 16'd0);

        // resp_done in the last wait cycle beats the timeout
        bus.i_s_request = 8'h04;
        step(1);
        bus.i_s_request = 8'h00;
        bus.cmd_ready = 1'b1;
        step(1);
        check("rd_stream2", 16'(bus.cmd_stream), 16'd2);
        step(1);
        bus.cmd_ready = 1'b0;
        step(9);
        bus.resp_done = 1'b1;
        step(1);
        bus.resp_done = 1'b0;
        check("rd_no_timeout", 16'(bus.timeout_flag), 16'd0);
        check("rd_idle", 16'(bus.busy), 16'd0);
        step(1);
        check("rd_no_timeout2", 16'(bus.timeout_flag), 16'd0);

        // Stream 3 disabled while its command is offered
        bus.i_s_request = 8'h08;
        step(1);
        bus.i_s_request = 8'h00;
        step(1);
        check("dis_valid", 16'(bus.cmd_valid), 16'd1);
        check("dis_stream3", 16'(bus.cmd_stream), 16'd3);
        bus.stream_active = 8'hF7;
        bus.cmd_ready = 1'b1;
        step(1);
        check("dis_valid_low", 16'(bus.cmd_valid), 16'd0);
        check("dis_pending", 16'(bus.pending), 16'h00);
        check("dis_busy", 16'(bus.busy), 16'd0);
        // last grant still 2, so streams {1,3} resolve to 3
        bus.stream_active = 8'hFF;
        bus.cmd_ready = 1'b0;
        bus.i_s_request = 8'h0A;
        step(1);
        bus.i_s_request = 8'h00;
        step(1);
        check("dis_last_unchanged", 16'(bus.cmd_stream), 16'd3);

        // Asynchronous reset during WAIT_RESP
        bus.cmd_ready = 1'b1;
        step(1);
        bus.cmd_ready = 1'b0;
        check("ar_busy_before", 16'(bus.busy), 16'd1);
        check("ar_pending_before", 16'(bus.pending), 16'h02);
        #3;
        reset = 1'b1;
        #1;
        check("ar_busy", 16'(bus.busy), 16'd0);
        check("ar_pending", 16'(bus.pending), 16'h00);
        check("ar_cmd_valid", 16'(bus.cmd_valid), 16'd0);
        check("ar_cmd_stream", 16'(bus.cmd_stream), 16'd0);
        check("ar_overrun", 16'(bus.overrun), 16'h00);
        check("ar_timeout", 16'(bus.timeout_flag), 16'd0);
        step(2);
        reset = 1'b0;
        bus.i_s_request = 8'h81;
        step(1);
        bus.i_s_request = 8'h00;
        check("ar_pending_after", 16'(bus.pending), 16'h81);
        step(1);
        check("ar_first_grant", 16'(bus.cmd_stream), 16'd0);
        check("ar_valid_after", 16'(bus.cmd_valid), 16'd1);
        step(12);
        check("ar_no_timeout", 16'(bus.timeout_flag), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
